// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair.
// Holds the receiver FSM state encoding and the bit-period helpers, so that
// uart_tx and uart_rx derive an identical clocks-per-bit figure from the
// same CLK_HZ / BIT_RATE parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } uart_rx_state_e;

  // Clocks per bit period (integer division, truncating).
  function automatic int unsigned calc_cpb(input int unsigned clk_hz,
                                           input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Offset from the start-bit edge to its centre.
  function automatic int unsigned calc_half(input int unsigned clk_hz,
                                            input int unsigned bit_rate);
    return calc_cpb(clk_hz, bit_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk     - sampling clock
//   resetn  - asynchronous active-low reset; both flops load RESET_VAL
//   d_i     - asynchronous input
//   q_o     - synchronised output (two cycles of latency)
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style asynchronous serial receiver.
// Synchronises the line, qualifies the start bit at its centre, then samples
// each data bit and the stop bit at their centres, LSB first.
// Ports:
//   clk               - system clock, rising edge
//   resetn            - asynchronous active-low reset
//   uart_rxd          - serial line, asynchronous, idles high
//   uart_rx_en        - enables detection of a new start bit
//   uart_rx_valid     - one-cycle strobe, uart_rx_data holds a good frame
//   uart_rx_data      - last good payload, held until the next valid
//   uart_rx_frame_err - one-cycle strobe, stop bit sampled low
//   uart_rx_break     - one-cycle strobe with frame_err when payload is all zero
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned CLK_HZ       = 20_000_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int unsigned CPB   = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF  = calc_half(CLK_HZ, BIT_RATE);
  localparam int unsigned CNT_W = $clog2(CPB + 1);
  localparam int unsigned BIT_W = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CPB_M1   = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);

  logic rxs;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .d_i   (uart_rxd),
    .q_o   (rxs)
  );

  uart_rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0]   shreg_q, shreg_d;
  logic [PAYLOAD_BITS-1:0]   data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      brk_q, brk_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs && uart_rx_en) begin
          state_d = RX_START;
          bit_d   = '0;
        end
      end

      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end
      end

      RX_DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
          shreg_d = {rxs, shreg_q[PAYLOAD_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = RX_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            brk_d   = (shreg_q == '0);
            state_d = RX_WAIT_HIGH;
          end
        end
      end

      RX_WAIT_HIGH: begin
        // A line held low must return high before a new start is accepted.
        cnt_d = '0;
        if (rxs) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_break     = brk_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receiving end of the 8N1 link driven by `uart_tx`. It synchronises the incoming line, detects start bits, and samples each bit at its centre. It presents each received byte with a one-cycle valid strobe and flags framing errors and line breaks. It sits beside `uart_tx` in the top level, so the design can take commands from the same serial port it reports on.

## Interface
Parameters:
- `BIT_RATE`, 9600: line rate in bits/s.
- `PAYLOAD_BITS`, 8: data bits per frame.
- `CLK_HZ`, 20_000_000: `clk` frequency in Hz.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `uart_rxd`, in, 1: serial line, asynchronous to `clk`; idles high.
- `uart_rx_en`, in, 1: enables start-bit detection.
- `uart_rx_valid`, out, 1: one-cycle strobe; `uart_rx_data` holds a good frame.
- `uart_rx_data`, out, PAYLOAD_BITS: last good byte; held until the next valid.
- `uart_rx_frame_err`, out, 1: one-cycle strobe when the stop bit is sampled low.
- `uart_rx_break`, out, 1: one-cycle strobe when a frame has all-zero data and a low stop bit.

## Operation
- Derived constants:
  - CPB = CLK_HZ / BIT_RATE, integer division (2083 at defaults).
  - HALF = CPB / 2.
  - Cycle counter width is clog2(CPB+1). Bit index width is clog2(PAYLOAD_BITS+1).
- `uart_rxd` passes through a 2-FF synchroniser reset to 1. All decisions use the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rxs`=0 and `uart_rx_en`=1, clear the counter and go to START. Call this cycle D.
  - START: at counter = HALF−1 (cycle D+HALF), sample `rxs`.
    - If `rxs`=1, the start was a false start; return to IDLE with no strobe.
    - If `rxs`=0, clear the counter and go to DATA.
  - DATA: sample every CPB cycles, LSB first. Bit k is sampled at D+HALF+(k+1)·CPB. After PAYLOAD_BITS samples, go to STOP.
  - STOP: sample at D+HALF+(PAYLOAD_BITS+1)·CPB.
    - If the sample is 1: load `uart_rx_data`, pulse `uart_rx_valid`, go to IDLE.
    - If the sample is 0: pulse `uart_rx_frame_err`. Also pulse `uart_rx_break` if the shifted data is all zero. `uart_rx_data` is not updated. Go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE on the first cycle with `rxs`=1. This stops a held-low line from re-triggering.
- `uart_rx_en` only gates the IDLE→START transition. A frame already in progress completes normally.
- At most one of valid / frame_err is asserted per frame. `uart_rx_break` is only asserted together with `uart_rx_frame_err`.

## Timing
- Reset values: all outputs 0, `uart_rx_data`=0, FSM in IDLE, both synchroniser flops 1.
- Reset applied mid-frame aborts immediately with no strobe. After release, the block waits in IDLE for a fresh falling edge.
- Latency from a `uart_rxd` falling edge to cycle D is 2 cycles (synchroniser).
- Strobes are registered and asserted on the cycle after the stop sample, i.e. D+HALF+(PAYLOAD_BITS+1)·CPB+1.
- Strobes are exactly one cycle wide. There is no backpressure; the consumer must capture the data on the valid strobe.
- Back-to-back frames: IDLE is re-entered HALF cycles before the nominal stop-bit end. A start bit that immediately follows the stop bit is therefore caught with no lost frame.
- Glitches: a low pulse shorter than HALF cycles at `rxs` produces no output.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state encoding;
  - a function computing CPB/HALF from CLK_HZ/BIT_RATE, so that `uart_tx` and `uart_rx` agree on the bit period.
- One sub-module: `uart_rx_sync`, the 2-FF synchroniser with reset value parameterised (1 here).

## Test plan
Bench parameters: CLK_HZ=1000, BIT_RATE=100 (CPB=10, HALF=5).
- Reset, line idle, en=1; send 0x55 -> one valid pulse with data=0x55, frame_err=0, pulse at the computed cycle ±0.
- Send 0x68 then 0x65 with no idle gap -> two valid pulses, data 0x68 then 0x65, CPB·10 cycles apart.
- Drive a 3-cycle low glitch -> no strobe; FSM back in IDLE; a following 0xA5 is received correctly.
- Send 0xA5 with stop bit 0 -> frame_err pulse, no valid, break=0, `uart_rx_data` unchanged.
- Hold line low for 20 bit times -> exactly one frame_err+break pulse; no further strobes until the line goes high; a later 0x0D is received.
- en=0 during a frame start -> ignored. Assert reset at bit 4 of a frame -> outputs 0, no strobe. Loopback from `uart_tx` sending "hello world\r\n" -> 13 matching bytes.
